// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Frame FSM states, parity encodings and the CTS synchroniser depth.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int CTS_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head word visible on rd_data with no read latency.
// Writes while full and reads while empty are ignored; count tracks occupancy.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (!wr_ok && rd_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter (5-9 data bits, optional parity, 1/2 stop bits, optional CTS).
// Start bit one cycle after a word lands in an empty FIFO; frames run back-to-back; ready drops when full.
module uart_tx_buffered import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int USE_CTS      = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [BITS_N-1:0]               data_tx,
    input  logic                            valid,
    output logic                            ready,
    input  logic                            cts_n,
    output logic                            uart_out,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(BITS_N);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_N - 1);
    localparam logic [FW-1:0] FULL_CNT  = FW'(FIFO_DEPTH);
    localparam logic          LAST_STOP = (STOP_BITS == 2);
    localparam bit            HAS_PAR   = (PARITY_TYPE != PARITY_NONE);
    localparam logic          ODD_INV   = (PARITY_TYPE == PARITY_ODD);

    uart_tx_state_t             state;
    logic [CW-1:0]              clk_cnt;
    logic [BW-1:0]              bit_idx;
    logic                       stop_cnt;
    logic [BITS_N-1:0]          shreg;
    logic                       par_bit;
    logic                       line_q;
    logic                       ready_q;
    logic [CTS_SYNC_STAGES-1:0] cts_sync;
    logic [BITS_N-1:0]          head;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       cts_ok;
    logic                       bit_end;
    logic                       frame_end;
    logic [FW-1:0]              count_next;

    sync_fifo #(
        .WIDTH (BITS_N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (data_tx),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign push      = valid && ready_q;
    assign cts_ok    = (USE_CTS == 0) || !cts_sync[CTS_SYNC_STAGES-1];
    assign bit_end   = (clk_cnt == LAST_CLK);
    assign frame_end = (state == STOP) && bit_end && (stop_cnt == LAST_STOP);
    assign pop       = !empty && cts_ok && ((state == IDLE) || frame_end);

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (!push && pop) begin
            count_next = fifo_count - 1'b1;
        end
    end

    // Looking at count_next keeps a fill from overflowing; the !full term delays reopening by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q  <= 1'b0;
            cts_sync <= '1;
        end else begin
            ready_q  <= (count_next != FULL_CNT) && !full;
            cts_sync <= {cts_sync[CTS_SYNC_STAGES-2:0], cts_n};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            line_q   <= 1'b1;
        end else begin
            if (state != IDLE) begin
                clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
            end
            if (pop) begin
                shreg   <= head;
                par_bit <= (^head) ^ ODD_INV;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state   <= START;
                        clk_cnt <= '0;
                        line_q  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        line_q  <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_BIT) begin
                            if (HAS_PAR) begin
                                state  <= PARITY;
                                line_q <= par_bit;
                            end else begin
                                state    <= STOP;
                                stop_cnt <= 1'b0;
                                line_q   <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            line_q  <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        stop_cnt <= 1'b0;
                        line_q   <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == LAST_STOP) begin
                            state  <= pop ? START : IDLE;
                            line_q <= !pop;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uart_out = line_q;
    assign busy     = (state != IDLE);
    assign ready    = ready_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: five instances cover default framing,
// odd/even parity, a FIFO burst, CTS gating and mid-frame reset.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] d   [5];
    logic       v   [5];
    logic       rdy [5];
    logic       cts [5];
    logic       uo  [5];
    logic       bsy [5];
    logic [4:0] cnt [5];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(434), .BITS_N(8), .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(16), .USE_CTS(0)) u0 (
        .clk(clk), .rst(rst), .data_tx(d[0][7:0]), .valid(v[0]), .ready(rdy[0]), .cts_n(cts[0]),
        .uart_out(uo[0]), .busy(bsy[0]), .fifo_count(cnt[0]));
    uart_tx_buffered #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(16), .USE_CTS(0)) u1 (
        .clk(clk), .rst(rst), .data_tx(d[1][7:0]), .valid(v[1]), .ready(rdy[1]), .cts_n(cts[1]),
        .uart_out(uo[1]), .busy(bsy[1]), .fifo_count(cnt[1]));
    uart_tx_buffered #(.CLKS_PER_BIT(4), .BITS_N(7), .PARITY_TYPE(1), .STOP_BITS(2), .FIFO_DEPTH(16), .USE_CTS(0)) u2 (
        .clk(clk), .rst(rst), .data_tx(d[2][6:0]), .valid(v[2]), .ready(rdy[2]), .cts_n(cts[2]),
        .uart_out(uo[2]), .busy(bsy[2]), .fifo_count(cnt[2]));
    uart_tx_buffered #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(2), .STOP_BITS(1), .FIFO_DEPTH(16), .USE_CTS(0)) u3 (
        .clk(clk), .rst(rst), .data_tx(d[3][7:0]), .valid(v[3]), .ready(rdy[3]), .cts_n(cts[3]),
        .uart_out(uo[3]), .busy(bsy[3]), .fifo_count(cnt[3]));
    uart_tx_buffered #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(16), .USE_CTS(1)) u4 (
        .clk(clk), .rst(rst), .data_tx(d[4][7:0]), .valid(v[4]), .ready(rdy[4]), .cts_n(cts[4]),
        .uart_out(uo[4]), .busy(bsy[4]), .fifo_count(cnt[4]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line pattern of one frame, index 0 = start bit; unused upper bits stay 1.
    function automatic logic [15:0] mk_frame(input logic [8:0] w, input int nb, input int par_en,
                                             input logic par);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int j = 0; j < nb; j++) f[1+j] = w[j];
        if (par_en != 0) f[1+nb] = par;
        return f;
    endfunction

    function automatic logic [8:0] burst_word(input int n);
        return 9'((n * 37 + 5) & 255);
    endfunction

    // Samples every cycle of the frame; adv=0 means the current negedge is already the first start cycle.
    task automatic expect_frame(input string tag, input int i, input int cpb, input int nbits,
                                input logic [15:0] exp, input bit adv);
        logic [15:0] cap;
        int          err;
        cap = '1;
        err = 0;
        for (int j = 0; j < nbits; j++) begin
            for (int c = 0; c < cpb; c++) begin
                if (adv || j != 0 || c != 0) @(negedge clk);
                if (c == cpb / 2) cap[j] = uo[i];
                if (uo[i] !== exp[j]) err++;
            end
        end
        chk({tag, "_bits"}, 32'(cap), 32'(exp));
        chk({tag, "_timing"}, err, 0);
    endtask

    task automatic push_word(input int i, input logic [8:0] w);
        d[i] = w;
        v[i] = 1'b1;
        @(negedge clk);
        v[i] = 1'b0;
    endtask

    task automatic wait_start(input int i, input int limit, output int n);
        n = 0;
        while (uo[i] !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 32'(uo[i]), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int lat;
        int low;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d[i]   = '0;
            v[i]   = 1'b0;
            cts[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy[0]), 0);
        chk("rst_line", 32'(uo[0]), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(rdy[0]), 1);
        chk("busy_after_rst", 32'(bsy[0]), 0);
        chk("count_after_rst", 32'(cnt[0]), 0);

        // Single word 0xA5 at 434 clocks per bit.
        push_word(0, 9'hA5);
        chk("count_after_push", 32'(cnt[0]), 1);
        chk("line_before_start", 32'(uo[0]), 1);
        expect_frame("a5", 0, 434, 10, mk_frame(9'hA5, 8, 0, 1'b0), 1'b1);
        chk("busy_last_stop", 32'(bsy[0]), 1);
        @(negedge clk);
        chk("busy_after_frame", 32'(bsy[0]), 0);
        chk("idle_line", 32'(uo[0]), 1);

        // 7 data bits, odd parity, 2 stop bits: 11 bit periods.
        push_word(2, 9'h03);
        expect_frame("odd03", 2, 4, 11, mk_frame(9'h03, 7, 1, 1'b1), 1'b1);
        @(negedge clk);
        chk("odd_busy_after", 32'(bsy[2]), 0);
        push_word(2, 9'h01);
        expect_frame("odd01", 2, 4, 11, mk_frame(9'h01, 7, 1, 1'b0), 1'b1);

        // Even parity, two words back-to-back.
        push_word(3, 9'h07);
        push_word(3, 9'h00);
        expect_frame("even07", 3, 4, 11, mk_frame(9'h07, 8, 1, 1'b1), 1'b0);
        expect_frame("even00", 3, 4, 11, mk_frame(9'h00, 8, 1, 1'b0), 1'b1);
        @(negedge clk);
        chk("even_busy_after", 32'(bsy[3]), 0);

        // Burst of 18 words with valid held high.
        fork
            begin
                int          n;
                int          g;
                int          ready_err;
                int          lag_err;
                int          rise_err;
                int          full_pops;
                int          max_cnt;
                bit          acc;
                bit          lag_prev;
                logic [4:0]  prev;
                n = 0; g = 0; ready_err = 0; lag_err = 0; rise_err = 0; full_pops = 0; max_cnt = 0;
                lag_prev = 1'b0;
                prev = cnt[1];
                while (n < 18 && g < 3000) begin
                    d[1] = burst_word(n);
                    v[1] = 1'b1;
                    acc  = rdy[1];
                    @(negedge clk);
                    g++;
                    if (acc) n++;
                    if (cnt[1] == 5'd16 && rdy[1]) ready_err++;
                    if (lag_prev && !(rdy[1] && cnt[1] == 5'd15)) rise_err++;
                    lag_prev = 1'b0;
                    if (prev == 5'd16 && cnt[1] == 5'd15) begin
                        full_pops++;
                        lag_prev = 1'b1;
                        if (rdy[1]) lag_err++;
                    end
                    if (int'(cnt[1]) > max_cnt) max_cnt = int'(cnt[1]);
                    prev = cnt[1];
                end
                v[1] = 1'b0;
                chk("burst_pushes", n, 18);
                chk("burst_max_count", max_cnt, 16);
                chk("burst_ready_low_when_full", ready_err, 0);
                chk("burst_full_pops", full_pops, 1);
                chk("burst_ready_lag", lag_err, 0);
                chk("burst_ready_rise", rise_err, 0);
            end
            begin
                wait_start(1, 50, lat);
                for (int f = 0; f < 18; f++) begin
                    expect_frame($sformatf("burst%0d", f), 1, 4, 10,
                                 mk_frame(burst_word(f), 8, 0, 1'b0), f != 0);
                end
                @(negedge clk);
                chk("burst_busy_after", 32'(bsy[1]), 0);
                chk("burst_count_after", 32'(cnt[1]), 0);
            end
        join

        // CTS gating: nothing leaves while cts_n is high.
        push_word(4, 9'h55);
        push_word(4, 9'h0F);
        push_word(4, 9'hC3);
        low = 0;
        repeat (20) begin
            @(negedge clk);
            if (uo[4] !== 1'b1 || bsy[4] !== 1'b0) low++;
        end
        chk("cts_hold_line", low, 0);
        chk("cts_hold_count", 32'(cnt[4]), 3);
        cts[4] = 1'b0;
        wait_start(4, 20, lat);
        chk("cts_latency", lat, 3);
        fork
            expect_frame("cts55", 4, 4, 10, mk_frame(9'h55, 8, 0, 1'b0), 1'b0);
            begin
                repeat (10) @(negedge clk);
                cts[4] = 1'b1;
            end
        join
        @(negedge clk);
        chk("cts_stop_line", 32'(uo[4]), 1);
        chk("cts_stop_busy", 32'(bsy[4]), 0);
        chk("cts_stop_count", 32'(cnt[4]), 2);
        repeat (10) @(negedge clk);
        chk("cts_still_idle", 32'({bsy[4], uo[4]}), 32'h1);

        // Reset in the middle of a data bit with five words queued.
        for (int k = 0; k < 6; k++) push_word(1, 9'(8'h80 + k));
        repeat (10) @(negedge clk);
        chk("pre_reset_count", 32'(cnt[1]), 5);
        chk("pre_reset_busy", 32'(bsy[1]), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_line", 32'(uo[1]), 1);
        chk("reset_count", 32'(cnt[1]), 0);
        chk("reset_busy", 32'(bsy[1]), 0);
        chk("reset_ready", 32'(rdy[1]), 0);
        chk("reset_flush_cts_inst", 32'(cnt[4]), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(rdy[1]), 1);
        push_word(1, 9'h3C);
        expect_frame("post_reset3c", 1, 4, 10, mk_frame(9'h3C, 8, 0, 1'b0), 1'b1);
        @(negedge clk);
        chk("post_reset_busy", 32'(bsy[1]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
